// File: rtl/exec_writeback_unit_pkg.sv
// Shared definitions for the execute/write-back stage and the 8x32 register array.
package exec_writeback_unit_pkg;

    localparam int unsigned BITS_DATA = 32;
    localparam int unsigned BITS_ADDR = 3;
    localparam int unsigned CNT_W     = $clog2(BITS_DATA);

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SLT = 3'b101,
        OP_SLL = 3'b110,
        OP_MUL = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/exec_writeback_unit_alu_comb.sv
// Single-cycle ALU for every opcode except MUL; yields result and signed overflow.
module exec_writeback_unit_alu_comb
    import exec_writeback_unit_pkg::*;
#(
    parameter int unsigned W = BITS_DATA
) (
    input  logic [2:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] result_c,
    output logic         ovf_c
);

    localparam int unsigned SHW = $clog2(W);

    always_comb begin
        result_c = '0;
        ovf_c    = 1'b0;
        case (op)
            OP_ADD: begin
                result_c = a + b;
                ovf_c    = (a[W-1] == b[W-1]) && (result_c[W-1] != a[W-1]);
            end
            OP_SUB: begin
                result_c = a - b;
                ovf_c    = (a[W-1] != b[W-1]) && (result_c[W-1] != a[W-1]);
            end
            OP_AND:  result_c = a & b;
            OP_OR:   result_c = a | b;
            OP_XOR:  result_c = a ^ b;
            OP_SLT:  result_c = W'($signed(a) < $signed(b));
            OP_SLL:  result_c = a << b[SHW-1:0];
            default: result_c = '0;
        endcase
    end

endmodule

// File: rtl/exec_writeback_unit.sv
// Execute stage: ALU ops in one cycle, 32-step shift-add multiply, and a
// write-back request toward the register array with valid/ready on both sides.
module exec_writeback_unit #(
    parameter int unsigned BITS_DATA = exec_writeback_unit_pkg::BITS_DATA,
    parameter int unsigned BITS_ADDR = exec_writeback_unit_pkg::BITS_ADDR,
    parameter int unsigned CNT_W     = $clog2(BITS_DATA)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           in_op,
    input  logic [BITS_DATA-1:0] in_a,
    input  logic [BITS_DATA-1:0] in_b,
    input  logic [BITS_ADDR-1:0] in_dst,
    output logic                 wb_valid,
    input  logic                 wb_ready,
    output logic [BITS_ADDR-1:0] wb_addr,
    output logic [BITS_DATA-1:0] wb_data,
    output logic                 wb_zero,
    output logic                 wb_ovf,
    output logic                 busy
);

    import exec_writeback_unit_pkg::*;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BITS_DATA - 1);

    state_e               state;
    logic [BITS_DATA-1:0] acc;
    logic [BITS_DATA-1:0] mcand;
    logic [BITS_DATA-1:0] mplier;
    logic [CNT_W-1:0]     cnt;
    logic [BITS_DATA-1:0] accNext;
    logic [BITS_DATA-1:0] aluResult;
    logic                 aluOvf;
    logic                 accept;

    exec_writeback_unit_alu_comb #(
        .W(BITS_DATA)
    ) uAlu (
        .op      (in_op),
        .a       (in_a),
        .b       (in_b),
        .result_c(aluResult),
        .ovf_c   (aluOvf)
    );

    // A finished result frees the stage in the same cycle it is consumed.
    assign in_ready = (state == S_IDLE) || ((state == S_DONE) && wb_ready);
    assign accept   = in_valid && in_ready;
    assign accNext  = mplier[0] ? (acc + mcand) : acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            cnt      <= '0;
            wb_valid <= 1'b0;
            wb_addr  <= '0;
            wb_data  <= '0;
            wb_zero  <= 1'b0;
            wb_ovf   <= 1'b0;
            busy     <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if ((state == S_DONE) && wb_ready) begin
                        wb_valid <= 1'b0;
                        state    <= S_IDLE;
                    end
                    if (accept) begin
                        wb_addr <= in_dst;
                        if (in_op == OP_MUL) begin
                            acc      <= '0;
                            mcand    <= in_a;
                            mplier   <= in_b;
                            cnt      <= '0;
                            busy     <= 1'b1;
                            wb_valid <= 1'b0;
                            state    <= S_MUL;
                        end else begin
                            wb_data  <= aluResult;
                            wb_zero  <= (aluResult == '0);
                            wb_ovf   <= aluOvf;
                            wb_valid <= 1'b1;
                            state    <= S_DONE;
                        end
                    end
                end
                S_MUL: begin
                    // One partial product per cycle, LSB of the multiplier first.
                    acc    <= accNext;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == CNT_LAST) begin
                        wb_data  <= accNext;
                        wb_zero  <= (accNext == '0);
                        wb_ovf   <= 1'b0;
                        wb_valid <= 1'b1;
                        busy     <= 1'b0;
                        state    <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/exec_writeback_unit.md
Name: exec_writeback_unit

Overview:
- Execute stage directly downstream of the 8x32 register array: consumes its two read operands plus an opcode and destination address, and computes the result.
- Returns the result as a write-back request (address + data) for the register array's write port.
- Single-cycle ALU ops and an iterative 32-cycle shift-add multiplier, with valid/ready handshakes on both sides.

Parameters:
- BITS_DATA, 32, operand/result width.
- BITS_ADDR, 3, register address width (8 registers).
- CNT_W, 5, multiply step counter width; equals clog2(BITS_DATA).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operation request valid.
- in_ready  output  1  unit can accept a request this cycle.
- in_op  input  3  opcode (see Behaviour).
- in_a  input  BITS_DATA  operand A (register array output 1).
- in_b  input  BITS_DATA  operand B (register array output 2).
- in_dst  input  BITS_ADDR  destination register address.
- wb_valid  output  1  write-back request valid.
- wb_ready  input  1  register array accepts write-back.
- wb_addr  output  BITS_ADDR  write-back destination.
- wb_data  output  BITS_DATA  result.
- wb_zero  output  1  result == 0.
- wb_ovf  output  1  signed overflow (ADD/SUB only, else 0).
- busy  output  1  multiply in progress.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - wb_valid=0, wb_addr=0, wb_data=0, wb_zero=0, wb_ovf=0, busy=0.
  - Counter and internal operand registers cleared.
  - Reset mid-multiply abandons the operation; no write-back is produced.
- Opcodes:
  - 000 ADD, 001 SUB (A-B).
  - 010 AND, 011 OR, 100 XOR.
  - 101 SLT: signed; result 1 if A<B else 0.
  - 110 SLL: A << B[4:0].
  - 111 MUL: low 32 bits of A*B.
- All arithmetic is modulo 2^BITS_DATA.
- wb_ovf for ADD = sign(A)==sign(B) && sign(R)!=sign(A); for SUB = sign(A)!=sign(B) && sign(R)!=sign(A).
- in_ready = (state==IDLE) || (state==DONE && wb_ready).
- Accept = in_valid && in_ready. in_op, in_a, in_b and in_dst are captured at accept; later changes on these inputs are ignored.
- FSM states: IDLE, MUL, DONE.
  - IDLE, accept non-MUL: result, flags and wb_addr registered; -> DONE. wb_valid is asserted the cycle after accept (latency 1).
  - IDLE, accept MUL: acc=0, mcand=A, mplier=B, cnt=0, busy=1; -> MUL.
  - MUL, each cycle:
    - if mplier[0], acc += mcand;
    - mcand <<= 1; mplier >>= 1; cnt++.
    - When cnt==31, after the add -> DONE with wb_data=acc.
    - Exactly 32 cycles in MUL; wb_valid is asserted 33 cycles after accept.
    - in_ready=0 throughout.
  - DONE: wb_valid=1.
    - wb_addr, wb_data and flags are held stable until the handshake (wb_valid && wb_ready).
    - On handshake, if in_valid: accept the new request in the same cycle (back-to-back; non-MUL gives one result per cycle).
    - On handshake without in_valid: -> IDLE with wb_valid=0.
    - Without handshake: remain in DONE.
- wb_zero = (wb_data==0), registered together with wb_data.
- busy = (state==MUL).
- in_valid while busy or stalled is not an error: the request waits, and the requester must hold its inputs stable.

Decomposition:
- Shared package holds:
  - opcode constants OP_ADD..OP_MUL (3-bit);
  - state encodings S_IDLE=2'd0, S_MUL=2'd1, S_DONE=2'd2;
  - BITS_DATA/BITS_ADDR defaults, shared with the register array.
- One natural sub-module: alu_comb, purely combinational for ops 000-110; it produces result and ovf.
- The multiplier datapath and FSM stay in the top module.

Test Plan:
- Reset mid-MUL: accept MUL 7*9, assert rst_n=0 at cycle 10 -> all outputs 0 immediately; after release, in_ready=1 and no wb_valid appears.
- ADD overflow: accept ADD A=0x7FFFFFFF, B=1, dst=3 -> next cycle wb_valid=1, wb_addr=3, wb_data=0x80000000, wb_ovf=1, wb_zero=0.
- SUB and SLT zero/sign: SUB A=5,B=5 -> wb_data=0, wb_zero=1. SLT A=0xFFFFFFFF(-1), B=1 -> wb_data=1.
- MUL timing: accept MUL A=0x12345678, B=0x10, dst=6 -> busy=1 and in_ready=0 for 32 cycles; wb_valid at cycle 33 with wb_data=0x23456780.
- Back-pressure: hold wb_ready=0 for 5 cycles after an XOR 0xF0F0F0F0^0xFFFF0000 -> wb_data stays 0x0F0FF0F0 and in_ready=0; wb_ready=1 -> handshake, then in_ready=1.
- Back-to-back streaming: wb_ready=1 and in_valid=1 continuously with ADD, OR, SLL (A=1,B=33 -> 2) -> one wb_valid per cycle, results in order, wb_addr matching each in_dst.
